sysbus_arbiter: RTL and testbench

Parametrised N-client arbiter that shares the single Sysbus master port of `top` among several requestors, starting with instruction fetch and the memory stage. Each client sees a private, protocol-identical Sysbus port. The arbiter grants one whole transaction at a time in round-robin order, then routes that transaction's request beats, acknowledges and response burst between the owner and the bus.

---
 rtl/sysbus_arbiter_pkg.sv | 20 ++
 rtl/sysbus_arbiter_rr_pick.sv | 38 +++
 rtl/sysbus_arbiter.sv | 140 ++++++++++++++
 tb/tb_sysbus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arb_pkg
// Brief    : State encoding and tag direction values for the Sysbus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sysbus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Finds the first active request scanning upward from rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_CLIENTS = 2
) (
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic [$clog2(NUM_CLIENTS)-1:0] rr_ptr,
    output logic                           valid,
    output logic [$clog2(NUM_CLIENTS)-1:0] index
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    int               w_k;
    logic [IDX_W-1:0] w_sel;

    // Scanning from the far end lets the closest hit to rr_ptr overwrite the rest.
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_k   = 0;
        w_sel = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            w_k   = (int'(rr_ptr) + i) % NUM_CLIENTS;
            w_sel = w_k[IDX_W-1:0];
            if (req[w_sel]) begin
                valid = 1'b1;
                index = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Brief    : Round-robin, whole-transaction arbiter sharing one Sysbus port.
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_CLIENTS    = 2,
    parameter int BEATS          = 8,
    parameter int TAG_DIR_BIT    = 12
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_CLIENTS-1:0]                       cl_reqcyc,
    input  logic [NUM_CLIENTS-1:0][BUS_DATA_WIDTH-1:0]   cl_req,
    input  logic [NUM_CLIENTS-1:0][BUS_TAG_WIDTH-1:0]    cl_reqtag,
    output logic [NUM_CLIENTS-1:0]                       cl_reqack,
    output logic [NUM_CLIENTS-1:0]                       cl_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]                    cl_resp,
    output logic [BUS_TAG_WIDTH-1:0]                     cl_resptag,
    input  logic [NUM_CLIENTS-1:0]                       cl_respack,
    output logic                                         bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]                    bus_req,
    output logic [BUS_TAG_WIDTH-1:0]                     bus_reqtag,
    input  logic                                         bus_reqack,
    input  logic                                         bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]                    bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]                     bus_resptag,
    output logic                                         bus_respack
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] c_beats = CNT_W'(BEATS);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(NUM_CLIENTS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_req_beat;
    logic             w_resp_beat;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last_beat;
    logic [IDX_W-1:0] w_next_ptr;

    rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr_pick (
        .req    (cl_reqcyc),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .index  (w_pick_idx)
    );

    assign w_req_beat  = bus_reqcyc & bus_reqack;
    assign w_resp_beat = bus_respcyc & bus_respack;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_last_beat = (w_cnt_inc == c_beats);
    assign w_next_ptr  = (r_owner == c_last) ? '0 : r_owner + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_req_beat) begin
                        r_cnt   <= '0;
                        r_state <= (bus_reqtag[TAG_DIR_BIT] == DIR_WRITE) ? WDATA : RESP;
                    end
                end
                WDATA: begin
                    if (w_req_beat) begin
                        r_cnt <= w_cnt_inc;
                        if (w_last_beat) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                RESP: begin
                    if (w_resp_beat) begin
                        r_cnt <= w_cnt_inc;
                        if (w_last_beat) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pure steering from registered state/owner: no latency added on any path.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        cl_reqack   = '0;
        cl_respcyc  = '0;
        cl_resp     = '0;
        cl_resptag  = '0;
        case (r_state)
            REQ, WDATA: begin
                bus_reqcyc         = cl_reqcyc[r_owner];
                bus_req            = cl_req[r_owner];
                bus_reqtag         = cl_reqtag[r_owner];
                cl_reqack[r_owner] = bus_reqack;
            end
            RESP: begin
                cl_respcyc[r_owner] = bus_respcyc;
                bus_respack         = cl_respack[r_owner];
                cl_resp             = bus_resp;
                cl_resptag          = bus_resptag;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_arbiter
// Brief    : Directed self-checking bench for sysbus_arbiter (2- and 4-client).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;
    import sysbus_arb_pkg::*;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int B  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [1:0]            cl_reqcyc;
    logic [1:0][DW-1:0]    cl_req;
    logic [1:0][TW-1:0]    cl_reqtag;
    logic [1:0]            cl_reqack;
    logic [1:0]            cl_respcyc;
    logic [DW-1:0]         cl_resp;
    logic [TW-1:0]         cl_resptag;
    logic [1:0]            cl_respack;
    logic                  bus_reqcyc;
    logic [DW-1:0]         bus_req;
    logic [TW-1:0]         bus_reqtag;
    logic                  bus_reqack;
    logic                  bus_respcyc;
    logic [DW-1:0]         bus_resp;
    logic [TW-1:0]         bus_resptag;
    logic                  bus_respack;

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (DW), .BUS_TAG_WIDTH (TW), .NUM_CLIENTS (2),
        .BEATS (B), .TAG_DIR_BIT (12)
    ) dut (
        .clk (clk), .reset (rst_n),
        .cl_reqcyc (cl_reqcyc), .cl_req (cl_req), .cl_reqtag (cl_reqtag),
        .cl_reqack (cl_reqack), .cl_respcyc (cl_respcyc), .cl_resp (cl_resp),
        .cl_resptag (cl_resptag), .cl_respack (cl_respack),
        .bus_reqcyc (bus_reqcyc), .bus_req (bus_req), .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack), .bus_respcyc (bus_respcyc), .bus_resp (bus_resp),
        .bus_resptag (bus_resptag), .bus_respack (bus_respack)
    );

    logic                  rst4_n;
    logic [3:0]            cl_reqcyc4;
    logic [3:0][DW-1:0]    cl_req4;
    logic [3:0][TW-1:0]    cl_reqtag4;
    logic [3:0]            cl_reqack4;
    logic [3:0]            cl_respcyc4;
    logic [DW-1:0]         cl_resp4;
    logic [TW-1:0]         cl_resptag4;
    logic [3:0]            cl_respack4;
    logic                  bus_reqcyc4;
    logic [DW-1:0]         bus_req4;
    logic [TW-1:0]         bus_reqtag4;
    logic                  bus_reqack4;
    logic                  bus_respcyc4;
    logic                  bus_respack4;

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (DW), .BUS_TAG_WIDTH (TW), .NUM_CLIENTS (4),
        .BEATS (2), .TAG_DIR_BIT (12)
    ) dut4 (
        .clk (clk), .reset (rst4_n),
        .cl_reqcyc (cl_reqcyc4), .cl_req (cl_req4), .cl_reqtag (cl_reqtag4),
        .cl_reqack (cl_reqack4), .cl_respcyc (cl_respcyc4), .cl_resp (cl_resp4),
        .cl_resptag (cl_resptag4), .cl_respack (cl_respack4),
        .bus_reqcyc (bus_reqcyc4), .bus_req (bus_req4), .bus_reqtag (bus_reqtag4),
        .bus_reqack (bus_reqack4), .bus_respcyc (bus_respcyc4), .bus_resp ('0),
        .bus_resptag ('0), .bus_respack (bus_respack4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int c, input logic [63:0] addr, input logic dir);
        cl_reqcyc[c] = 1'b1;
        cl_req[c]    = addr;
        cl_reqtag[c] = {dir, 12'(c + 16'h0a0)};
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bus_reqcyc"}, bus_reqcyc, 0);
        check({tag, "_bus_respack"}, bus_respack, 0);
        check({tag, "_cl_reqack"}, cl_reqack, 0);
        check({tag, "_cl_respcyc"}, cl_respcyc, 0);
        check({tag, "_state"}, dut.r_state, IDLE);
    endtask

    // Called one cycle after the grant edge; runs one read through to beat stop_after.
    task automatic serve_read(input int c, input logic [63:0] addr, input logic [63:0] base,
                              input int ack_wait, input int stall_at, input int stall_len,
                              input int stop_after);
        logic [1:0] onehot;
        int beats;
        int stalled;
        onehot = 2'b01 << c;
        #1;
        check("rd_grant_cyc", bus_reqcyc, 1);
        check("rd_grant_addr", bus_req, addr);
        for (int w = 0; w < ack_wait; w++) begin
            check("rd_wait_ack", cl_reqack, 0);
            tick();
            check("rd_wait_hold", bus_reqcyc, 1);
        end
        bus_reqack = 1'b1;
        #1;
        check("rd_reqack", cl_reqack, onehot);
        tick();
        cl_reqcyc[c] = 1'b0;
        bus_reqack   = 1'b0;
        beats   = 0;
        stalled = 0;
        while (beats < stop_after) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(beats);
            bus_resptag = cl_reqtag[c];
            if (beats == stall_at && stalled < stall_len) begin
                cl_respack[c] = 1'b0;
                #1;
                check("stall_respack", bus_respack, 0);
                check("stall_cnt", 64'(dut.r_cnt), 64'(beats));
                tick();
                stalled++;
            end else begin
                cl_respack[c] = 1'b1;
                #1;
                check("rd_respcyc", cl_respcyc, onehot);
                check("rd_resp", cl_resp, base + 64'(beats));
                check("rd_respack", bus_respack, 1);
                if (beats == 0) check("rd_resptag", cl_resptag, cl_reqtag[c]);
                tick();
                beats++;
            end
        end
        if (stop_after == B) begin
            bus_respcyc = 1'b0;
            cl_respack  = '0;
            #1;
        end
    endtask

    task automatic serve_write(input int c, input logic [63:0] addr, input logic [63:0] base);
        logic [1:0] onehot;
        int nbeats;
        onehot = 2'b01 << c;
        nbeats = 0;
        #1;
        check("wr_grant_addr", bus_req, addr);
        bus_reqack = 1'b1;
        #1;
        check("wr_reqack", cl_reqack, onehot);
        if (bus_reqcyc && bus_reqack) nbeats++;
        tick();
        for (int i = 0; i < B; i++) begin
            cl_req[c] = base + 64'(i);
            #1;
            check("wr_data", bus_req, base + 64'(i));
            check("wr_state", dut.r_state, WDATA);
            if (bus_reqcyc && bus_reqack) nbeats++;
            tick();
        end
        cl_reqcyc[c] = 1'b0;
        bus_reqack   = 1'b0;
        #1;
        check("wr_beats", 64'(nbeats), 64'(B + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int grants[5];
        int ng;
        rst_n = 1'b0; rst4_n = 1'b0;
        cl_reqcyc = '0; cl_req = '0; cl_reqtag = '0; cl_respack = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        cl_reqcyc4 = '0; cl_req4 = '0; cl_reqtag4 = '0; cl_respack4 = '0;
        bus_reqack4 = 1'b0; bus_respcyc4 = 1'b0;
        tick(); tick();
        check_idle("reset");
        check("reset_rr_ptr", dut.r_rr_ptr, 0);
        rst_n = 1'b1;

        // single read from client 0, bus acks after two cycles
        raise(0, 64'h1000, DIR_READ);
        #1;
        check("latency_still_idle", bus_reqcyc, 0);
        tick();
        serve_read(0, 64'h1000, 64'hA0, 2, -1, 0, B);
        check_idle("rd_done");
        check("rd_done_rr_ptr", dut.r_rr_ptr, 1);

        // simultaneous requests after reset alternate 0,1,0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        raise(0, 64'h2000, DIR_READ);
        raise(1, 64'h3000, DIR_READ);
        tick();
        serve_read(0, 64'h2000, 64'hC0, 0, -1, 0, B);
        check("turnaround_idle", bus_reqcyc, 0);
        tick();
        serve_read(1, 64'h3000, 64'hD0, 0, -1, 0, B);
        raise(0, 64'h2100, DIR_READ);
        raise(1, 64'h3100, DIR_READ);
        tick();
        serve_read(0, 64'h2100, 64'hE0, 0, -1, 0, B);
        cl_reqcyc[1] = 1'b0;

        // write from client 1 with 8 data beats
        raise(1, 64'h4000, DIR_WRITE);
        tick();
        serve_write(1, 64'h4000, 64'hB0);
        check_idle("wr_done");
        check("wr_done_rr_ptr", dut.r_rr_ptr, 0);

        // stray response outside RESP is not forwarded
        cl_respack  = 2'b11;
        bus_respcyc = 1'b1;
        bus_resp    = 64'h55;
        #1;
        check("stray_respcyc", cl_respcyc, 0);
        check("stray_respack", bus_respack, 0);
        bus_respcyc = 1'b0;
        cl_respack  = '0;

        // response backpressure: 3 stalled cycles at beat 3
        raise(0, 64'h5000, DIR_READ);
        tick();
        serve_read(0, 64'h5000, 64'hF0, 0, 3, 3, B);
        check_idle("bp_done");

        // reset in the middle of a read burst
        raise(0, 64'h6000, DIR_READ);
        tick();
        serve_read(0, 64'h6000, 64'h10, 0, -1, 0, 4);
        check("mid_state_resp", dut.r_state, RESP);
        rst_n = 1'b0;
        tick();
        check_idle("midrst");
        check("midrst_cl_resp", cl_resp, 0);
        check("midrst_rr_ptr", dut.r_rr_ptr, 0);
        check("midrst_cnt", 64'(dut.r_cnt), 0);
        rst_n = 1'b1;
        bus_respcyc = 1'b0;
        cl_respack  = '0;
        raise(1, 64'h7000, DIR_READ);
        tick();
        serve_read(1, 64'h7000, 64'h20, 0, -1, 0, B);
        check_idle("post_rst");

        // four clients requesting continuously: order 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            cl_req4[i]    = 64'(i);
            cl_reqtag4[i] = {DIR_READ, 12'(i)};
        end
        cl_reqcyc4   = 4'hf;
        cl_respack4  = 4'hf;
        bus_reqack4  = 1'b1;
        bus_respcyc4 = 1'b1;
        rst4_n = 1'b1;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            tick();
            if (bus_reqcyc4 && bus_reqack4) begin
                grants[ng] = int'(bus_req4[1:0]);
                check("rr4_onehot", cl_reqack4, 4'b0001 << bus_req4[1:0]);
                ng++;
            end
        end
        check("rr4_grant_count", 64'(ng), 5);
        check("rr4_g0", 64'(grants[0]), 0);
        check("rr4_g1", 64'(grants[1]), 1);
        check("rr4_g2", 64'(grants[2]), 2);
        check("rr4_g3", 64'(grants[3]), 3);
        check("rr4_g4", 64'(grants[4]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
